// File: rtl/tt_chk_pkg.sv
// rtl/tt_chk_pkg.sv - shared types and defaults for the truth-table response checker
//
// Contents:
//   tt_state_t            FSM state encoding (TT_IDLE, TT_COLLECT, TT_DONE)
//   TT_N_IN_DEFAULT       default number of DUT inputs
//   TT_EXPECTED_DEFAULT   default expected table (4-input odd parity)
package tt_chk_pkg;

    typedef enum logic [1:0] {
        TT_IDLE    = 2'd0,
        TT_COLLECT = 2'd1,
        TT_DONE    = 2'd2
    } tt_state_t;

    localparam int TT_N_IN_DEFAULT = 4;

    // Bit i is the expected output for input code i; 16'h6996 is XOR of four inputs.
    localparam logic [15:0] TT_EXPECTED_DEFAULT = 16'h6996;

endpackage

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - collects (code, f) beats and checks them against an expected truth table
//
// Optional feature: define TT_CHK_DUP_EN to add the dup_err port and its logic.
//
// Parameters:
//   N_IN             number of DUT inputs; table depth D = 2**N_IN
//   EXPECTED         D-bit expected table, bit i = f(code i)
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   start            clear results and begin a collection pass
//   in_valid         beat offered
//   in_ready         beat accepted when in_valid && in_ready (combinational)
//   in_code          input combination applied to the DUT
//   in_f             DUT output observed for in_code
//   busy             high while collecting
//   done             high once every code has been seen
//   pass             valid with done; 1 iff no mismatches
//   covered          bit i set once code i has been accepted
//   signature        bit i = first observed f for code i
//   mismatch_cnt     number of codes whose first observation differs from EXPECTED
//   first_err_code   code of the earliest mismatch
//   first_err_valid  first_err_code holds a real value
//   dup_err          (TT_CHK_DUP_EN only) sticky: a repeated code disagreed with its first value
module truth_table_checker
    import tt_chk_pkg::*;
#(
    parameter int                        N_IN     = TT_N_IN_DEFAULT,
    parameter logic [(1 << N_IN) - 1:0]  EXPECTED = TT_EXPECTED_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN-1:0]             in_code,
    input  logic                        in_f,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [(1 << N_IN) - 1:0]    covered,
    output logic [(1 << N_IN) - 1:0]    signature,
    output logic [N_IN:0]               mismatch_cnt,
    output logic [N_IN-1:0]             first_err_code,
    output logic                        first_err_valid
`ifdef TT_CHK_DUP_EN
    ,
    output logic                        dup_err
`endif
);

    localparam int             D       = 1 << N_IN;
    localparam logic [D-1:0]   ONE_D   = D'(1);
    localparam logic [N_IN:0]  CNT_ONE = (N_IN + 1)'(1);

    tt_state_t      state;
    tt_state_t      next_state;
    logic           accept;
    logic [D-1:0]   code_onehot;
    logic           cover_full;
    logic           code_seen;
    logic           code_bad;

    assign code_onehot = ONE_D << in_code;
    // Coverage including the beat being accepted this cycle, so DONE is
    // reached on the same edge that accepts the last missing code.
    assign cover_full  = &(covered | code_onehot);
    assign code_seen   = covered[in_code];
    assign code_bad    = (in_f != EXPECTED[in_code]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            TT_IDLE: begin
                if (start) next_state = TT_COLLECT;
            end
            TT_COLLECT: begin
                // A restart takes priority over the beat offered alongside it.
                in_ready = !start;
                if (in_valid && !start && cover_full) next_state = TT_DONE;
            end
            TT_DONE: begin
                if (start) next_state = TT_COLLECT;
            end
            default: next_state = TT_IDLE;
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            covered         <= '0;
            signature       <= '0;
            mismatch_cnt    <= '0;
            first_err_code  <= '0;
            first_err_valid <= 1'b0;
        end else if (accept && !code_seen) begin
            // Only the first observation of a code counts; repeats are absorbed.
            covered[in_code]   <= 1'b1;
            signature[in_code] <= in_f;
            if (code_bad) begin
                mismatch_cnt <= mismatch_cnt + CNT_ONE;
                if (!first_err_valid) begin
                    first_err_code  <= in_code;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

`ifdef TT_CHK_DUP_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            dup_err <= 1'b0;
        end else if (accept && code_seen && (in_f != signature[in_code])) begin
            dup_err <= 1'b1;
        end
    end
`endif

    // Decodes of the state register and result registers only.
    assign busy = (state == TT_COLLECT);
    assign done = (state == TT_DONE);
    assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - directed self-checking bench for truth_table_checker
module tb_truth_table_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_f;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] covered;
    logic [15:0] signature;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_err_code;
    logic        first_err_valid;
`ifdef TT_CHK_DUP_EN
    logic        dup_err;
`endif

    int checks;
    int failures;

    truth_table_checker dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_code         (in_code),
        .in_f            (in_f),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .covered         (covered),
        .signature       (signature),
        .mismatch_cnt    (mismatch_cnt),
        .first_err_code  (first_err_code),
        .first_err_valid (first_err_valid)
`ifdef TT_CHK_DUP_EN
        ,
        .dup_err         (dup_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic parity4(input int c);
        logic [3:0] v;
        v = 4'(c);
        return ^v;
    endfunction

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Full in-order sweep; codes whose bit is set in flip_mask get the wrong f.
    task automatic sweep(input logic [15:0] flip_mask, input string tag);
        for (int c = 0; c < 16; c++) begin
            in_valid = 1'b1;
            in_code  = 4'(c);
            in_f     = parity4(c) ^ flip_mask[c];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_ready code=%0d: got %b want 1", tag, c, in_ready);
            end
            tick();
            if (c < 15) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_early_done code=%0d: got %b want 0", tag, c, done);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_code = '0; in_f = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, busy, done, pass, first_err_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", {in_ready, busy, done, pass, first_err_valid});
        end
        checks++;
        if ({covered, signature, mismatch_cnt, first_err_code} !== '0) begin
            failures++;
            $display("FAIL reset_data: cov=%h sig=%h cnt=%0d fec=%0d want all 0",
                     covered, signature, mismatch_cnt, first_err_code);
        end
`ifdef TT_CHK_DUP_EN
        checks++;
        if (dup_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_dup_err: got %b want 0", dup_err);
        end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_ready: ready=%b busy=%b want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_parity_sweep();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || covered !== 16'h0) begin
            failures++;
            $display("FAIL start_busy: busy=%b cov=%h want 1 0000", busy, covered);
        end
        sweep(16'h0000, "parity");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL parity_done: done=%b busy=%b pass=%b want 1 0 1", done, busy, pass);
        end
        checks++;
        if (signature !== 16'h6996 || covered !== 16'hFFFF) begin
            failures++;
            $display("FAIL parity_sig: sig=%h cov=%h want 6996 ffff", signature, covered);
        end
        checks++;
        if (mismatch_cnt !== 5'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_cnt: cnt=%0d fev=%b want 0 0", mismatch_cnt, first_err_valid);
        end
    endtask

    task automatic test_mismatch();
        pulse_start();
        sweep(16'h0208, "mism");
        checks++;
        if (mismatch_cnt !== 5'd2 || pass !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL mism_cnt: cnt=%0d pass=%b done=%b want 2 0 1", mismatch_cnt, pass, done);
        end
        checks++;
        if (first_err_code !== 4'd3 || first_err_valid !== 1'b1) begin
            failures++;
            $display("FAIL mism_first: code=%0d valid=%b want 3 1", first_err_code, first_err_valid);
        end
        checks++;
        if (signature !== 16'h6B9E) begin
            failures++;
            $display("FAIL mism_sig: got %h want 6b9e", signature);
        end
    endtask

    task automatic test_reverse_dup();
        int beats;
        pulse_start();
        beats = 0;
        for (int c = 15; c >= 0; c--) begin
            for (int rep = 0; rep < ((c == 7) ? 2 : 1); rep++) begin
                in_valid = 1'b1;
                in_code  = 4'(c);
                in_f     = parity4(c) ^ (rep == 1);
                tick();
                beats++;
                if (c != 0) begin
                    checks++;
                    if (done !== 1'b0) begin
                        failures++;
                        $display("FAIL rev_early_done beat=%0d: got %b want 0", beats, done);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || beats != 17) begin
            failures++;
            $display("FAIL rev_done: done=%b pass=%b beats=%0d want 1 1 17", done, pass, beats);
        end
        checks++;
        if (signature !== 16'h6996 || mismatch_cnt !== 5'd0) begin
            failures++;
            $display("FAIL rev_sig: sig=%h cnt=%0d want 6996 0", signature, mismatch_cnt);
        end
`ifdef TT_CHK_DUP_EN
        checks++;
        if (dup_err !== 1'b1) begin
            failures++;
            $display("FAIL rev_dup_err: got %b want 1", dup_err);
        end
`endif
    endtask

    task automatic test_restart();
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_code  = 4'(c);
            in_f     = parity4(c) ^ (c == 1);
            tick();
        end
        checks++;
        if (mismatch_cnt !== 5'd1 || covered !== 16'h00FF) begin
            failures++;
            $display("FAIL restart_pre: cnt=%0d cov=%h want 1 00ff", mismatch_cnt, covered);
        end
        in_code = 4'd8;
        in_f    = 1'b1;
        start   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL restart_ready: got %b want 0", in_ready);
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (covered !== 16'h0 || signature !== 16'h0 || mismatch_cnt !== 5'd0
            || first_err_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: cov=%h sig=%h cnt=%0d fev=%b busy=%b want 0 0 0 0 1",
                     covered, signature, mismatch_cnt, first_err_valid, busy);
        end
        sweep(16'h0000, "restart");
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h6996) begin
            failures++;
            $display("FAIL restart_done: done=%b pass=%b sig=%h want 1 1 6996", done, pass, signature);
        end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_code  = 4'(c);
            in_f     = parity4(c) ^ (c == 2);
            tick();
        end
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done, pass, first_err_valid} !== 5'b0
            || {covered, signature, mismatch_cnt, first_err_code} !== '0) begin
            failures++;
            $display("FAIL midrst_values: rdy=%b busy=%b done=%b cov=%h sig=%h cnt=%0d fec=%0d fev=%b want all 0",
                     in_ready, busy, done, covered, signature, mismatch_cnt, first_err_code, first_err_valid);
        end
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || covered !== 16'h0) begin
            failures++;
            $display("FAIL midrst_idle: ready=%b cov=%h want 0 0000", in_ready, covered);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_done_hold();
        pulse_start();
        sweep(16'h0020, "hold");
        in_valid = 1'b1;
        in_code  = 4'd0;
        in_f     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || done !== 1'b1 || pass !== 1'b0) begin
                failures++;
                $display("FAIL hold_flags cyc=%0d: ready=%b done=%b pass=%b want 0 1 0", i, in_ready, done, pass);
            end
            checks++;
            if (covered !== 16'hFFFF || signature !== 16'h69B6 || mismatch_cnt !== 5'd1
                || first_err_code !== 4'd5 || first_err_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_data cyc=%0d: cov=%h sig=%h cnt=%0d fec=%0d fev=%b want ffff 69b6 1 5 1",
                         i, covered, signature, mismatch_cnt, first_err_code, first_err_valid);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_parity_sweep();
        test_mismatch();
        test_reverse_dup();
        test_restart();
        test_mid_reset();
        test_done_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
